// File: rtl/aukv_gpr_regfile_mp.sv
// Parametrised Auk-V integer register file: two combinational read ports, two
// prioritised write ports, optional write-to-read bypass and a per-register busy scoreboard.
module aukv_gpr_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1data,
    output logic [XLEN-1:0] o_rs2data,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    input  logic            i_we0,
    input  logic [AW-1:0]   i_rd0_addr,
    input  logic [XLEN-1:0] i_rd0_data,
    input  logic            i_we1,
    input  logic [AW-1:0]   i_rd1_addr,
    input  logic [XLEN-1:0] i_rd1_data,
    input  logic            i_issue,
    input  logic [AW-1:0]   i_issue_rd
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             we0_eff;
    logic             we1_eff;
    logic             issue_eff;
    logic             we0_shadowed;

    // Register 0 is invisible to writes and issues when it is hardwired to zero.
    assign we0_eff   = i_we0   && !(ZERO_REG && (i_rd0_addr == '0));
    assign we1_eff   = i_we1   && !(ZERO_REG && (i_rd1_addr == '0));
    assign issue_eff = i_issue && !(ZERO_REG && (i_issue_rd == '0));

    assign we0_shadowed = we1_eff && (i_rd1_addr == i_rd0_addr);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0_eff && !we0_shadowed) begin
                regs[i_rd0_addr] <= i_rd0_data;
            end
            if (we1_eff) begin
                regs[i_rd1_addr] <= i_rd1_data;
            end
        end
    end

    // Set after clear so a new producer issued alongside the old one's writeback stays tracked.
    always_comb begin
        busy_nxt = busy;
        if (we0_eff) begin
            busy_nxt[i_rd0_addr] = 1'b0;
        end
        if (we1_eff) begin
            busy_nxt[i_rd1_addr] = 1'b0;
        end
        if (issue_eff) begin
            busy_nxt[i_issue_rd] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;
        logic            hit0;
        logic            hit1;

        assign addr = (p == 0) ? i_rs1_addr : i_rs2_addr;
        assign hit0 = BYPASS && we0_eff && (i_rd0_addr == addr);
        assign hit1 = BYPASS && we1_eff && (i_rd1_addr == addr);

        // Reset forces zero even over bypassed write data so outputs are clean while held.
        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if (hit1) begin
                data = i_rd1_data;
            end else if (hit0) begin
                data = i_rd0_data;
            end
            if (hit0 || hit1) begin
                bsy = 1'b0;
            end
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
            if (!i_rstn) begin
                data = '0;
                bsy  = 1'b0;
            end
        end
    end

    assign o_rs1data  = g_rd[0].data;
    assign o_rs2data  = g_rd[1].data;
    assign o_rs1_busy = g_rd[0].bsy;
    assign o_rs2_busy = g_rd[1].bsy;

endmodule
